// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings for the multicycle shift controller
//
// Purpose : FSM state encoding and operation-select encodings shared by
//           multicycle_shift_ctrl and shift_step.
// Ports   : none (package).

package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Operation select carried on dir.
  localparam logic DIR_SHL = 1'b0;  // logical left shift, zero fill
  localparam logic DIR_SAR = 1'b1;  // arithmetic right shift, sign fill

  // Bits moved per SHIFT cycle in the wide-step mode.
  localparam int FAST_STEP = 4;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shifter (1 or 4 bits)
//
// Purpose : Shifts in by one bit, or by four bits when step4 is high.
//           Left shifts fill with zero, right shifts replicate the MSB.
// Ports   : in    [WIDTH-1:0]  operand
//           dir                0 = left, 1 = arithmetic right
//           step4              1 = move four bits, 0 = move one bit
//           out   [WIDTH-1:0]  shifted operand

module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             dir,
  input  logic             step4,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in;
    if (dir == DIR_SAR) begin
      if (step4) out = {{FAST_STEP{in[WIDTH-1]}}, in[WIDTH-1:FAST_STEP]};
      else       out = {in[WIDTH-1], in[WIDTH-1:1]};
    end else begin
      if (step4) out = {in[WIDTH-1-FAST_STEP:0], {FAST_STEP{1'b0}}};
      else       out = {in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/multicycle_shift_ctrl.sv
// rtl/multicycle_shift_ctrl.sv - multicycle left/arithmetic-right shift controller
//
// Purpose : Accepts one shift request in IDLE, shifts the latched word one
//           bit per SHIFT cycle, then pulses done for one cycle in DONE.
//           Latency from accept edge to the done cycle is shamt+1 cycles.
//           Build macro SHIFT_FAST_STEP_EN: move four bits per SHIFT cycle
//           while the remaining count is at least four.
// Ports   : clock                   rising-edge clock
//           reset                   synchronous, active-high
//           start                   request strobe, sampled only in IDLE
//           data_in [WIDTH-1:0]     operand, latched on accept
//           shamt   [SHW-1:0]       unsigned shift amount, latched on accept
//           dir                     0 = logical left, 1 = arithmetic right
//           busy                    high whenever the state is not IDLE
//           done                    one-cycle result-valid pulse
//           result  [WIDTH-1:0]     working register, held until next accept

module multicycle_shift_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   count_q, count_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             step4;
  logic [SHW-1:0]   step_amt;
  logic [WIDTH-1:0] step_out;

`ifdef SHIFT_FAST_STEP_EN
  assign step4 = (count_q >= SHW'(FAST_STEP));
`else
  assign step4 = 1'b0;
`endif

  assign step_amt = step4 ? SHW'(FAST_STEP) : SHW'(1);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .in    (work_q),
    .dir   (dir_q),
    .step4 (step4),
    .out   (step_out)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    dir_d   = dir_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = data_in;
          count_d = shamt;
          dir_d   = dir;
          state_d = (shamt == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        // count is never zero here in normal flow; the guard keeps it from
        // wrapping if the state is ever entered with nothing left to do.
        if (count_q == '0) begin
          state_d = DONE;
        end else begin
          work_d  = step_out;
          count_d = count_q - step_amt;
          if (count_d == '0) state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      count_q <= '0;
      dir_q   <= DIR_SHL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = work_q;

endmodule

// File: tb/tb_multicycle_shift_ctrl.sv
// tb/tb_multicycle_shift_ctrl.sv - directed self-checking bench for multicycle_shift_ctrl

module tb_multicycle_shift_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        dir;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  multicycle_shift_ctrl #(
    .WIDTH (32),
    .SHW   (5)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .shamt   (shamt),
    .dir     (dir),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int s);
`ifdef SHIFT_FAST_STEP_EN
    return s / 4 + s % 4 + 1;
`else
    return s + 1;
`endif
  endfunction

  // Called just after a negedge. Drives one request, then counts cycles
  // until done. repulse_at > 0 re-pulses start with other operands at that
  // cycle of the operation.
  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic dr,
                        input int repulse_at, output int lat, output logic [31:0] res);
    data_in = d;
    shamt   = s;
    dir     = dr;
    start   = 1'b1;
    lat     = 0;
    res     = '0;
    while (lat < 100) begin
      @(negedge clock);
      start = 1'b0;
      lat++;
      check("busy_in_flight", {31'd0, busy}, 32'd1);
      if (done) break;
      if (lat == repulse_at) begin
        start   = 1'b1;
        data_in = ~d;
        shamt   = 5'd1;
        dir     = ~dr;
      end
    end
    if (lat >= 100) check("done_timeout", 32'd0, 32'd1);
    res = result;
  endtask

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic        dr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10] = '{
    '{32'h0000_0001, 5'd4,  1'b0, 32'h0000_0010},
    '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF},
    '{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF},
    '{32'h0000_0003, 5'd31, 1'b0, 32'h8000_0000},
    '{32'h7000_0000, 5'd3,  1'b1, 32'h0E00_0000},
    '{32'hF000_00F0, 5'd4,  1'b1, 32'hFF00_000F},
    '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF},
    '{32'h0000_0003, 5'd9,  1'b0, 32'h0000_0600},
    '{32'h1234_5678, 5'd8,  1'b0, 32'h3456_7800},
    '{32'h8765_4321, 5'd16, 1'b1, 32'hFFFF_8765}
  };

  initial begin
    int          lat;
    logic [31:0] res;

    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    shamt   = '0;
    dir     = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_result", result,        32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].d, vecs[i].s, vecs[i].dr, 0, lat, res);
      check($sformatf("lat_%0d", i), lat, exp_lat(int'(vecs[i].s)));
      check($sformatf("res_%0d", i), res, vecs[i].exp);
      @(negedge clock);
      check($sformatf("done_once_%0d", i), {31'd0, done}, 32'd0);
      check($sformatf("idle_%0d", i),      {31'd0, busy}, 32'd0);
      check($sformatf("hold_%0d", i),      result,        vecs[i].exp);
    end

`ifdef SHIFT_FAST_STEP_EN
    run_op(32'h0000_0003, 5'd9, 1'b0, 0, lat, res);
    check("fast_lat", lat, 32'd4);
    check("fast_res", res, 32'h0000_0600);
    @(negedge clock);
`endif

    // Start re-pulsed during SHIFT is ignored.
    run_op(32'h0000_0001, 5'd6, 1'b0, 2, lat, res);
    check("repulse_lat", lat, exp_lat(6));
    check("repulse_res", res, 32'h0000_0040);
    @(negedge clock);
    check("repulse_idle", {31'd0, busy}, 32'd0);

    // Start re-pulsed during the DONE cycle is ignored too.
    run_op(32'h0000_0001, 5'd2, 1'b0, 0, lat, res);
    start   = 1'b1;
    data_in = 32'h5555_5555;
    shamt   = 5'd3;
    @(negedge clock);
    start = 1'b0;
    check("done_start_ignored_busy", {31'd0, busy}, 32'd0);
    check("done_start_ignored_res",  result,        32'h0000_0004);

    // Reset on the 3rd SHIFT cycle of a shamt=10 operation.
    data_in = 32'h0000_0005;
    shamt   = 5'd10;
    dir     = 1'b0;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy",   {31'd0, busy}, 32'd0);
    check("abort_done",   {31'd0, done}, 32'd0);
    check("abort_result", result,        32'd0);
    reset = 1'b0;
    run_op(32'h0000_0001, 5'd2, 1'b0, 0, lat, res);
    check("post_abort_lat", lat, exp_lat(2));
    check("post_abort_res", res, 32'h0000_0004);
    @(negedge clock);

    // Reset wins over start on the same edge.
    reset   = 1'b1;
    start   = 1'b1;
    data_in = 32'h0000_00FF;
    shamt   = 5'd3;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    check("rst_prio_busy",   {31'd0, busy}, 32'd0);
    check("rst_prio_result", result,        32'd0);
    @(negedge clock);
    check("rst_prio_stays_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_shift_ctrl.md
MULTICYCLE_SHIFT_CTRL -- requirements
Module: multicycle_shift_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data word width in bits.
REQ-002 SHALL have parameter SHW, default 5, giving the shift-amount width; WIDTH = 2**SHW.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset sampled on the rising edge of clock.
REQ-005 SHALL have port start, input, 1, the request strobe, sampled only while busy=0.
REQ-006 SHALL have port data_in, input, WIDTH, the operand, latched when start is accepted.
REQ-007 SHALL have port shamt, input, SHW, the unsigned shift amount, latched when start is accepted.
REQ-008 SHALL have port dir, input, 1, the operation select: 0 = logical left shift, 1 = arithmetic right shift; latched when start is accepted.
REQ-009 SHALL have port busy, output, 1, asserted while an operation is in flight.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse marking result as valid.
REQ-011 SHALL have port result, output, WIDTH, the shifted word.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-013 SHALL accept start only in IDLE, and SHALL ignore start in SHIFT or DONE, with no queuing.
- On acceptance: latch data_in into the working register, shamt into the count, and dir.
- If shamt != 0, go to SHIFT; if shamt = 0, go to DONE.
REQ-014 SHALL shift the working register by one bit per SHIFT cycle and decrement count by 1.
- Left shift: LSB fill is 0.
- Right shift: MSB fill is the MSB, i.e. sign replication.
REQ-015 SHALL move from SHIFT to DONE on the cycle in which count goes from 1 to 0.
REQ-016 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-017 SHALL assert busy if and only if the state is not IDLE.
REQ-018 SHALL give a latency, from the start-accept edge to the done cycle, of shamt+1 cycles.
- shamt = 0 gives 1 cycle.
- shamt = 31 gives 32 cycles.
REQ-019 SHALL drive result from the working register.
- result is only meaningful while done=1.
- result holds its value through IDLE until the next start is accepted.
REQ-020 SHALL treat shamt arithmetic as unsigned modulo 2**SHW, with no wrap below 0; count never underflows.
REQ-021 SHALL give reset priority over start when both are high on the same edge.

Reset
REQ-022 SHALL, on reset, set state to IDLE and force busy=0, done=0, result=0, count=0 and the latched dir=0.
REQ-023 SHALL, on reset in SHIFT or DONE, abort the operation with no done pulse; start is accepted on the first edge after reset deasserts.

Configuration
REQ-024 SHALL, with macro SHIFT_FAST_STEP_EN defined, shift by 4 bits and subtract 4 from count on each SHIFT cycle where count >= 4, and otherwise by 1 bit.
- Latency becomes floor(shamt/4) + (shamt mod 4) + 1.
REQ-025 SHALL, with SHIFT_FAST_STEP_EN undefined, behave exactly as REQ-014 and REQ-018.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the dir encodings in the shared package shift_pkg.
REQ-027 SHALL instantiate one sub-module, shift_step, a combinational single-step shifter with inputs in, dir and step4 and output out; the controller holds all state.

Verification
REQ-028 SHALL cover this scenario: data_in=32'h0000_0001, shamt=4, dir=0 -> busy for 5 cycles, done on the 5th cycle, result=32'h0000_0010.
REQ-029 SHALL cover this scenario: data_in=32'h8000_0000, shamt=31, dir=1 -> done 32 cycles after accept, result=32'hFFFF_FFFF.
REQ-030 SHALL cover this scenario: shamt=0, data_in=32'hDEAD_BEEF -> done on the next cycle, result=32'hDEAD_BEEF, SHIFT never entered.
REQ-031 SHALL cover this scenario: start re-pulsed with new operands during SHIFT -> ignored; result reflects the first operands only.
REQ-032 SHALL cover this scenario: reset asserted on the 3rd SHIFT cycle of a shamt=10 operation -> next cycle busy=0, done=0, result=0, no done pulse; a new start accepted immediately after.
REQ-033 SHALL cover this scenario: with SHIFT_FAST_STEP_EN defined, data_in=32'h0000_0003, shamt=9, dir=0 -> latency 4 cycles, result=32'h0000_0600.
